sta_mirror_reader: RTL and testbench

Read-side sequencer for the status mirror simple-dual-port RAM in the raw 10G link status path.
- On a start command it scans a contiguous (wrapping) range of mirror entries.
- It drives the RAM read address and absorbs the RAM's fixed read latency.
- It presents each entry on a valid/ready stream, with index and last marker, to the status export/CSR logic.
- It sits between the mirror RAM read port and the status consumer, in the RAM read-clock domain.

---
 rtl/sta_mirror_reader.sv | 188 ++++++++++++++++++
 tb/tb_sta_mirror_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_mirror_reader.sv
// sta_mirror_reader: read-side sequencer for the link status mirror RAM.
// Scans a wrapping range of mirror entries, hides the RAM read latency and
// streams each entry out with its index and a last marker.
module sta_mirror_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_entries,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LATENCY + 2);
  localparam logic [ADDR_WIDTH:0] ONE_LEFT = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  scan_empty;

  // Tag stage aligned with ram_rd_addr, then RD_LATENCY stages matching the RAM.
  logic                  vld_p0;
  logic                  last_p0;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [RD_LATENCY-1:0] last_pipe;
  logic [ADDR_WIDTH-1:0] addr_pipe [RD_LATENCY];

  // Shift-register FIFO; entry 0 is the head and directly drives the outputs.
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [CNT_W-1:0]      fifo_count;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [INF_W-1:0]      inflight;
  logic [CNT_W-1:0]      wr_idx;
  logic [CNT_W-1:0]      count_next;

  assign push    = vld_pipe[RD_LATENCY-1];
  assign pop     = m_valid & m_ready;
  assign m_data  = fifo_data[0];
  assign m_addr  = fifo_addr[0];
  assign m_last  = fifo_last[0];

  // Occupancy bookkeeping: reads in flight, FIFO write slot and next count.
  always_comb begin
    inflight = INF_W'(vld_p0);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + INF_W'(vld_pipe[i]);
    end
    wr_idx = pop ? fifo_count - 1'b1 : fifo_count;
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + 1'b1;
    end else if (!push && pop) begin
      count_next = fifo_count - 1'b1;
    end
    // A pop this cycle frees a slot, so it counts toward the credit.
    issue = (state == ISSUE) &&
            (int'(fifo_count) + int'(inflight) < FIFO_DEPTH + int'(pop));
  end

  // Scan sequencer: start capture, read issue, drain and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      remaining   <= '0;
      scan_empty  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_rd_addr <= '0;
      vld_p0      <= 1'b0;
      last_p0     <= 1'b0;
    end else begin
      done    <= 1'b0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_ptr     <= start_addr;
            remaining  <= num_entries;
            scan_empty <= (num_entries == '0);
            busy       <= 1'b1;
            state      <= (num_entries == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            ram_rd_addr <= rd_ptr;
            rd_ptr      <= rd_ptr + 1'b1;
            remaining   <= remaining - 1'b1;
            vld_p0      <= 1'b1;
            last_p0     <= (remaining == ONE_LEFT);
            if (remaining == ONE_LEFT) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (inflight == '0 && (scan_empty || (pop && m_last))) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag shift pipeline tracking each read through the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        addr_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= vld_p0;
      last_pipe[0] <= last_p0;
      addr_pipe[0] <= ram_rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  // Output FIFO: capture RAM data with its tag, shift forward on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= '0;
      fifo_last  <= '0;
      m_valid    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        if (push && wr_idx == CNT_W'(i)) begin
          fifo_data[i] <= ram_rd_data;
          fifo_addr[i] <= addr_pipe[RD_LATENCY-1];
          fifo_last[i] <= last_pipe[RD_LATENCY-1];
        end else if (pop) begin
          fifo_data[i] <= fifo_data[i+1];
          fifo_addr[i] <= fifo_addr[i+1];
          fifo_last[i] <= fifo_last[i+1];
        end
      end
      if (push && wr_idx == CNT_W'(FIFO_DEPTH - 1)) begin
        fifo_data[FIFO_DEPTH-1] <= ram_rd_data;
        fifo_addr[FIFO_DEPTH-1] <= addr_pipe[RD_LATENCY-1];
        fifo_last[FIFO_DEPTH-1] <= last_pipe[RD_LATENCY-1];
      end
      fifo_count <= count_next;
      m_valid    <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_sta_mirror_reader.sv
// Bench for sta_mirror_reader: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=2 run the same directed scans against a sync-RAM model.
module tb_sta_mirror_reader;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   num_entries = '0;

  logic          busy0, busy1, done0, done1, mval0, mval1, mlast0, mlast1;
  logic [1:0]    bz, dn, mv, ml;
  logic [AW-1:0] ma0, ma1, rda0, rda1;
  logic [DW-1:0] md0, md1, rdd0, rdd1, r1_stage;
  logic [DW-1:0] mem [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int scan_sa = 0;
  int scan_n = 0;
  int xfers [2];
  int first_v [2];
  int last_x [2];
  int done_due [2];
  int done_cyc [2];
  logic [DW-1:0] first_d [2];
  logic [DW-1:0] last_d [2];
  logic [AW-1:0] last_a [2];
  logic          stalled [2];
  logic [DW-1:0] hold_d [2];
  logic [AW-1:0] hold_a [2];
  logic          hold_l [2];

  assign bz = {busy1, busy0};
  assign dn = {done1, done0};
  assign mv = {mval1, mval0};
  assign ml = {mlast1, mlast0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sta_mirror_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .num_entries(num_entries), .busy(busy0), .done(done0), .ram_rd_addr(rda0),
    .ram_rd_data(rdd0), .m_valid(mval0), .m_ready(m_ready), .m_data(md0),
    .m_addr(ma0), .m_last(mlast0));

  sta_mirror_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .num_entries(num_entries), .busy(busy1), .done(done1), .ram_rd_addr(rda1),
    .ram_rd_data(rdd1), .m_valid(mval1), .m_ready(m_ready), .m_data(md1),
    .m_addr(ma1), .m_last(mlast1));

  // Mirror RAM models: latency 1 (plain sync read) and latency 2 (output register).
  always @(posedge clk) rdd0 <= mem[rda0];
  always @(posedge clk) begin
    r1_stage <= mem[rda1];
    rdd1     <= r1_stage;
  end

  function automatic logic [63:0] entry(input int k);
    logic [31:0] kk;
    kk = k;
    return {32'hA5A5_0000 | kk, ~kk};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard: the i-th transfer of a scan must be entry (sa+i) mod 16.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          v;
        logic          l;
        int            ea;
        int            fc;
        d  = (k == 0) ? md0 : md1;
        a  = (k == 0) ? ma0 : ma1;
        v  = mv[k];
        l  = ml[k];
        fc = (k == 0) ? int'(u_dut0.fifo_count) : int'(u_dut1.fifo_count);
        checks++;
        if (dn[k] !== (cyc == done_due[k])) begin
          errors++;
          $display("FAIL done dut%0d cyc %0d got %0b want %0b", k, cyc, dn[k], (cyc == done_due[k]));
        end
        if (dn[k] === 1'b1) begin
          done_cyc[k] = cyc;
          checks++;
          if (bz[k] !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done dut%0d got %0b want 0", k, bz[k]);
          end
        end
        checks++;
        if (fc > DEPTH) begin
          errors++;
          $display("FAIL fifo_bound dut%0d got %0d want <= %0d", k, fc, DEPTH);
        end
        if (stalled[k]) begin
          checks++;
          if (!(v === 1'b1 && d === hold_d[k] && a === hold_a[k] && l === hold_l[k])) begin
            errors++;
            $display("FAIL stall_hold dut%0d got v%0b a%0h d%0h want v1 a%0h d%0h",
                     k, v, a, d, hold_a[k], hold_d[k]);
          end
        end
        if (v === 1'b1) begin
          if (first_v[k] < 0) first_v[k] = cyc;
          if (m_ready === 1'b1) begin
            checks++;
            if (xfers[k] >= scan_n) begin
              errors++;
              $display("FAIL extra_xfer dut%0d got addr %0h want no transfer", k, a);
            end else begin
              ea = (scan_sa + xfers[k]) % 16;
              if (a !== ea[AW-1:0] || d !== entry(ea) || l !== (xfers[k] == scan_n - 1)) begin
                errors++;
                $display("FAIL xfer dut%0d #%0d got a%0h d%0h l%0b want a%0h d%0h l%0b",
                         k, xfers[k], a, d, l, ea, entry(ea), (xfers[k] == scan_n - 1));
              end
            end
            if (xfers[k] == 0) first_d[k] = d;
            if (l === 1'b1) begin
              last_d[k]   = d;
              last_a[k]   = a;
              done_due[k] = cyc + 1;
            end
            last_x[k] = cyc;
            xfers[k]++;
          end
        end
        stalled[k] = v && !m_ready;
        hold_d[k]  = d;
        hold_a[k]  = a;
        hold_l[k]  = l;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] sa, input logic [AW:0] n);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      xfers[k] = 0; first_v[k] = -1; last_x[k] = -1; done_cyc[k] = -1;
      first_d[k] = '0; last_d[k] = '0; last_a[k] = '0;
    end
    scan_sa = int'(sa);
    scan_n  = int'(n);
    start = 1'b1; start_addr = sa; num_entries = n;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit mid);
    int n;
    n = 0;
    while (!(done_cyc[0] >= 0 && done_cyc[1] >= 0) && n < budget) begin
      @(posedge clk);
      #1;
      if (rnd) m_ready = ($urandom_range(0, 99) < 30);
      if (mid && n == 4) begin
        start = 1'b1; start_addr = 4'd5; num_entries = 5'd7;
      end else if (mid && n == 5) begin
        start = 1'b0;
      end
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL done_timeout got %0d cycles want < %0d", n, budget);
    end
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl0"}, {bz[0], dn[0], mv[0], ml[0], ma0, rda0}, '0);
    chk({tag, "_dat0"}, md0, '0);
    chk({tag, "_ctl1"}, {bz[1], dn[1], mv[1], ml[1], ma1, rda1}, '0);
    chk({tag, "_dat1"}, md1, '0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) mem[k] = entry(k);
    for (int k = 0; k < 2; k++) begin
      xfers[k] = 0; first_v[k] = -1; last_x[k] = -1; done_due[k] = -1; done_cyc[k] = -1;
      stalled[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full scan from 0, always ready
    m_ready = 1'b1;
    do_start(4'd0, 5'd16);
    wait_done(300, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("full_count", xfers[k], 16);
      chk("full_contig", last_x[k] - first_v[k], 15);
      chk("full_latency", first_v[k] - start_cyc, 3 + k);
      chk("full_done_gap", done_cyc[k] - last_x[k], 1);
      chk("full_first_data", first_d[k], 64'hA5A5_0000_FFFF_FFFF);
      chk("full_last_data", last_d[k], 64'hA5A5_000F_FFFF_FFF0);
      chk("full_last_addr", last_a[k], 4'd15);
    end

    // Wrapping scan 14,15,0,1
    do_start(4'd14, 5'd4);
    wait_done(300, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("wrap_count", xfers[k], 4);
      chk("wrap_first_data", first_d[k], 64'hA5A5_000E_FFFF_FFF1);
      chk("wrap_last_data", last_d[k], 64'hA5A5_0001_FFFF_FFFE);
      chk("wrap_last_addr", last_a[k], 4'd1);
    end

    // Empty scan: busy one cycle, done the next, no data
    do_start(4'd0, 5'd0);
    done_due[0] = start_cyc + 1;
    done_due[1] = start_cyc + 1;
    @(negedge clk);
    chk("zero_busy", bz, 2'b11);
    chk("zero_novalid_a", mv, 2'b00);
    @(negedge clk);
    chk("zero_busy_off", bz, 2'b00);
    chk("zero_done", dn, 2'b11);
    @(negedge clk);
    chk("zero_done_off", dn, 2'b00);
    chk("zero_novalid_b", mv, 2'b00);
    for (int k = 0; k < 2; k++) chk("zero_count", xfers[k], 0);

    // Full scan under random 30% ready
    do_start(4'd0, 5'd16);
    wait_done(1500, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("bp_count", xfers[k], 16);
      chk("bp_first_data", first_d[k], 64'hA5A5_0000_FFFF_FFFF);
      chk("bp_last_addr", last_a[k], 4'd15);
    end

    // Start pulsed mid-scan is ignored
    do_start(4'd10, 5'd16);
    wait_done(300, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("mid_count", xfers[k], 16);
      chk("mid_first_data", first_d[k], 64'hA5A5_000A_FFFF_FFF5);
      chk("mid_last_data", last_d[k], 64'hA5A5_0009_FFFF_FFF6);
    end

    // Reset after six transfers abandons the scan
    do_start(4'd0, 5'd16);
    n = 0;
    while (xfers[0] < 6 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_wait_timeout", (n >= 100), 1'b0);
    #2 rst_n = 1'b0;
    done_due[0] = -1;
    done_due[1] = -1;
    #1;
    chk_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", dn, 2'b00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_start(4'd3, 5'd2);
    wait_done(100, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("post_count", xfers[k], 2);
      chk("post_first_data", first_d[k], 64'hA5A5_0003_FFFF_FFFC);
      chk("post_last_data", last_d[k], 64'hA5A5_0004_FFFF_FFFB);
      chk("post_last_addr", last_a[k], 4'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
